// File: rtl/conv_pkg.sv
// Shared constants and window-indexing helper for the 5x5 convolution window generator.
package conv_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int K          = 5;
  localparam int WIN_N      = K * K;

  // Window element (r,c) lives at element index r*K+c of the flattened bus.
  function automatic int elem_offset(input int r, input int c, input int data_w);
    return (r * K + c) * data_w;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-row delay line: circular RAM with one pointer, read-before-write.
// The output is the word written DEPTH enabled cycles ago.
module conv_line_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;

  assign rd_data = mem[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // RAM contents are deliberately not reset; output gating hides stale data.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-stream to 5x5 sliding-window generator (valid convolution, no padding).
// Optional macro CONV_WIN_LAST_EN adds out_last, flagging the final window of each frame.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIN_N*DATA_W-1:0] win_data
`ifdef CONV_WIN_LAST_EN
  ,
  output logic                    out_last
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic                    out_valid_q, out_valid_d;
  logic [WIN_N*DATA_W-1:0] win_q, win_d;
  logic                    accept;

  logic [DATA_W-1:0] lb_in  [K-1];
  logic [DATA_W-1:0] lb_out [K-1];
  logic [DATA_W-1:0] col_vec [K];

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign win_data  = win_q;

  // Buffer i delays by (i+1) rows; all advance only on accepted beats.
  assign lb_in[0] = in_data;
  for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
    if (gi > 0) begin : g_chain
      assign lb_in[gi] = lb_out[gi-1];
    end
    conv_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W)
    ) u_lb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (accept),
      .wr_data (lb_in[gi]),
      .rd_data (lb_out[gi])
    );
  end

  // Row 0 of the window is the oldest line, row K-1 the incoming pixel.
  for (genvar gr = 0; gr < K - 1; gr++) begin : g_colvec
    assign col_vec[gr] = lb_out[K-2-gr];
  end
  assign col_vec[K-1] = in_data;

`ifdef CONV_WIN_LAST_EN
  logic last_q, last_d;
  assign out_last = last_q;
`endif

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    win_d       = win_q;
`ifdef CONV_WIN_LAST_EN
    last_d      = last_q;
`endif
    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
`ifdef CONV_WIN_LAST_EN
      last_d      = 1'b0;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
`ifdef CONV_WIN_LAST_EN
        last_d      = 1'b0;
`endif
      end
      if (accept) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            win_d[elem_offset(r, c, DATA_W) +: DATA_W] = win_q[elem_offset(r, c + 1, DATA_W) +: DATA_W];
          end
          win_d[elem_offset(r, K - 1, DATA_W) +: DATA_W] = col_vec[r];
        end
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (row_q >= ROW_MIN && col_q >= COL_MIN) begin
          out_valid_d = 1'b1;
`ifdef CONV_WIN_LAST_EN
          last_d      = (row_q == ROW_LAST) && (col_q == COL_LAST);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      win_q       <= '0;
`ifdef CONV_WIN_LAST_EN
      last_q      <= 1'b0;
`endif
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
`ifdef CONV_WIN_LAST_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on an 8x8 frame; frame-array model of valid 5x5 windows.
module tb_conv_window_gen;

  localparam int DW = 32;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NE = 25;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            inValid;
  logic [DW-1:0]   inData;
  logic            inReady;
  logic            outValid;
  logic            outReady;
  logic [NE*DW-1:0] winData;
  logic            outLast;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [NE*DW-1:0] win;
    logic             last;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] img [H][W];
  int          mr = 0;
  int          mc = 0;
  logic [31:0] gotE0[$], gotE12[$], gotE24[$];
  bit          gotLast[$];

  always #5 clk = ~clk;

  conv_window_gen #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_ready  (inReady),
    .out_valid (outValid),
    .out_ready (outReady),
    .win_data  (winData)
`ifdef CONV_WIN_LAST_EN
    ,
    .out_last  (outLast)
`endif
  );

`ifndef CONV_WIN_LAST_EN
  assign outLast = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkWindow(input logic [NE*DW-1:0] exp);
    checks++;
    if (winData !== exp) begin
      int bad = 0;
      fails++;
      for (int i = NE - 1; i >= 0; i--) begin
        if (winData[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
      end
      $display("[TB] FAIL win_data elem %0d: got %0h expected %0h at %0t",
               bad, winData[bad*DW +: DW], exp[bad*DW +: DW], $time);
    end
  endtask

  // Model: store the frame, emit window rows mr-4..mr / cols mc-4..mc on each accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      mr = 0;
      mc = 0;
    end else begin
      bit pending, consume, acc;
      pending = (expQ.size() != 0);
      consume = pending && outReady;
      acc     = inValid && (!pending || outReady);
      checkOutput("out_valid", outValid, pending);
      checkOutput("in_ready", inReady, !pending || outReady);
      if (pending && outValid === 1'b1) begin
        checkWindow(expQ[0].win);
`ifdef CONV_WIN_LAST_EN
        checkOutput("out_last", outLast, expQ[0].last);
`endif
      end
      if (clear) begin
        expQ.delete();
        mr = 0;
        mc = 0;
      end else begin
        if (consume) begin
          gotE0.push_back(expQ[0].win[0 +: DW]);
          gotE12.push_back(expQ[0].win[12*DW +: DW]);
          gotE24.push_back(expQ[0].win[24*DW +: DW]);
          gotLast.push_back(expQ[0].last);
          void'(expQ.pop_front());
        end
        if (acc) begin
          img[mr][mc] = inData;
          if (mr >= 4 && mc >= 4) begin
            exp_t e;
            for (int rr = 0; rr < 5; rr++)
              for (int cc = 0; cc < 5; cc++)
                e.win[(rr*5+cc)*DW +: DW] = img[mr-4+rr][mc-4+cc];
            e.last = (mr == H - 1) && (mc == W - 1);
            expQ.push_back(e);
          end
          mc++;
          if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] p);
    bit ok;
    int n = 0;
    inValid = 1'b1;
    inData  = p;
    do begin
      @(negedge clk);
      ok = inReady;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept_timeout: pixel %0d not accepted after %0d cycles", p, n);
    end
  endtask

  task automatic streamFrame(input int base);
    for (int p = 0; p < W * H; p++) applyStimulus(base + p);
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearLog();
    gotE0.delete();
    gotE12.delete();
    gotE24.delete();
    gotLast.delete();
  endtask

  task automatic checkFrame(input string tag, input int idx, input int base, input bit withFirst);
    if (withFirst) begin
      checkOutput({tag, "_first_e0"},  gotE0[idx],  base + 0);
      checkOutput({tag, "_first_e12"}, gotE12[idx], base + 18);
      checkOutput({tag, "_first_e24"}, gotE24[idx], base + 36);
    end
    checkOutput({tag, "_last_e0"},   gotE0[idx+15],  base + 27);
    checkOutput({tag, "_last_e24"},  gotE24[idx+15], base + 63);
    checkOutput({tag, "_last_flag"}, gotLast[idx+15], 1);
    checkOutput({tag, "_prev_flag"}, gotLast[idx+14], 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    clear    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_in_ready", inReady, 1);
    checkOutput("rst_win_zero", (winData == '0), 1);
    checkOutput("rst_out_last", outLast, 0);
    repeat (2) @(posedge clk);
    #1 outReady = 1'b1;
    rst_n = 1'b1;

    // Scenario 1: single frame, free-flowing output.
    clearLog();
    streamFrame(0);
    idle(3);
    checkOutput("s1_count", gotE0.size(), 16);
    checkFrame("s1", 0, 0, 1);

    // Scenario 2: 3-cycle stall on the first window.
    clearLog();
    fork
      streamFrame(0);
      begin
        int n = 0;
        while (outValid !== 1'b1 && n < 500) begin
          @(posedge clk);
          #1;
          n++;
        end
        checkOutput("s2_window_seen", outValid, 1);
        outReady = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          checkOutput("s2_stall_in_ready", inReady, 0);
        end
        outReady = 1'b1;
      end
    join
    idle(3);
    checkOutput("s2_count", gotE0.size(), 16);
    checkFrame("s2", 0, 0, 1);

    // Scenario 3: two frames back-to-back.
    clearLog();
    streamFrame(0);
    streamFrame(100);
    idle(3);
    checkOutput("s3_count", gotE0.size(), 32);
    checkFrame("s3a", 0, 0, 1);
    checkFrame("s3b", 16, 100, 1);

    // Scenario 4: async reset mid-frame with a window pending.
    for (int p = 0; p <= 44; p++) applyStimulus(p);
    inValid  = 1'b0;
    outReady = 1'b0;
    checkOutput("s4_pre_rst_valid", outValid, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s4_async_valid", outValid, 0);
    checkOutput("s4_async_win", (winData == '0), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    outReady = 1'b1;
    clearLog();
    streamFrame(0);
    idle(3);
    checkOutput("s4_count", gotE0.size(), 16);
    checkFrame("s4", 0, 0, 1);

    // Scenario 5: clear concurrent with the beat carrying p=20.
    for (int p = 0; p < 20; p++) applyStimulus(p);
    inValid = 1'b1;
    inData  = 20;
    clear   = 1'b1;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    inValid = 1'b0;
    checkOutput("s5_clear_valid", outValid, 0);
    clearLog();
    streamFrame(0);
    idle(3);
    checkOutput("s5_count", gotE0.size(), 16);
    checkFrame("s5", 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
